// File: rtl/generic_maj5.sv
// Five-input bitwise majority voter with a registered vote and sticky
// per-input dissent flags that identify which voter disagreed.
module generic_maj5 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] E,
  input  logic             clr,
  output logic [WIDTH-1:0] X,
  output logic [WIDTH-1:0] X_q,
  output logic             unanimous,
  output logic [4:0]       dissent,
  output logic [4:0]       dissent_q
);

  logic [WIDTH-1:0] vote;
  logic [WIDTH-1:0] vote_d;
  logic [WIDTH-1:0] vote_q;
  logic [4:0]       dis;
  logic [4:0]       dis_acc_d;
  logic [4:0]       dis_acc_q;
  logic             agree;

  // Per-lane vote as the OR of all ten 3-of-5 product terms.
  always_comb begin
    vote = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      vote[i] = (A[i] & B[i] & C[i]) | (A[i] & B[i] & D[i]) |
                (A[i] & B[i] & E[i]) | (A[i] & C[i] & D[i]) |
                (A[i] & C[i] & E[i]) | (A[i] & D[i] & E[i]) |
                (B[i] & C[i] & D[i]) | (B[i] & C[i] & E[i]) |
                (B[i] & D[i] & E[i]) | (C[i] & D[i] & E[i]);
    end
  end

  always_comb begin
    dis    = '0;
    dis[0] = |(A ^ vote);
    dis[1] = |(B ^ vote);
    dis[2] = |(C ^ vote);
    dis[3] = |(D ^ vote);
    dis[4] = |(E ^ vote);
  end

  always_comb begin
    agree = (A == B) && (A == C) && (A == D) && (A == E);
  end

  // Set wins over clear: a clear cycle still captures that cycle's dissent.
  always_comb begin
    vote_d    = vote;
    dis_acc_d = clr ? dis : (dis_acc_q | dis);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vote_q    <= '0;
      dis_acc_q <= '0;
    end else begin
      vote_q    <= vote_d;
      dis_acc_q <= dis_acc_d;
    end
  end

  assign X         = vote;
  assign X_q       = vote_q;
  assign unanimous = agree;
  assign dissent   = dis;
  assign dissent_q = dis_acc_q;

endmodule

// File: tb/tb_generic_maj5.sv
// Directed bench for generic_maj5 at WIDTH=1 and WIDTH=4.
module tb_generic_maj5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  logic       a1, b1, c1, d1, e1;
  logic       x1, xq1, un1;
  logic [4:0] dis1, disq1;

  logic [3:0] a4, b4, c4, d4, e4;
  logic [3:0] x4, xq4;
  logic       un4;
  logic [4:0] dis4, disq4;

  generic_maj5 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .C(c1), .D(d1), .E(e1), .clr(clr),
    .X(x1), .X_q(xq1), .unanimous(un1), .dissent(dis1), .dissent_q(disq1)
  );

  generic_maj5 #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .A(a4), .B(b4), .C(c4), .D(d4), .E(e4), .clr(clr),
    .X(x4), .X_q(xq4), .unanimous(un4), .dissent(dis4), .dissent_q(disq4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [4:0] v;    // v[0]=A .. v[4]=E
    logic       x;
    logic       un;
    logic [4:0] dis;
  } vec_t;

  vec_t tbl[32];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic set1(input logic [4:0] v);
    a1 = v[0]; b1 = v[1]; c1 = v[2]; d1 = v[3]; e1 = v[4];
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    set1(5'b11111);
    a4 = '0; b4 = '0; c4 = '0; d4 = '0; e4 = '0;

    for (int i = 0; i < 32; i++) begin
      tbl[i].v   = 5'(i);
      tbl[i].x   = ($countones(5'(i)) >= 3);
      tbl[i].un  = (i == 0) || (i == 31);
      tbl[i].dis = tbl[i].x ? ~5'(i) : 5'(i);
    end

    #3;
    chk("reset_xq", {31'b0, xq1}, 32'd0);
    chk("reset_disq", {27'b0, disq1}, 32'd0);
    chk("x_in_reset", {31'b0, x1}, 32'd1);

    // Exhaustive combinational sweep, run while reset is held.
    for (int i = 0; i < 32; i++) begin
      set1(tbl[i].v);
      #2;
      chk($sformatf("x_%05b", tbl[i].v), {31'b0, x1}, {31'b0, tbl[i].x});
      chk($sformatf("un_%05b", tbl[i].v), {31'b0, un1}, {31'b0, tbl[i].un});
      chk($sformatf("dis_%05b", tbl[i].v), {27'b0, dis1}, {27'b0, tbl[i].dis});
    end

    set1(5'b00111); #1; chk("x_two_below", {31'b0, x1}, 32'd1);
    set1(5'b00011); #1; chk("x_two_ones", {31'b0, x1}, 32'd0);
    set1(5'b00111); #1; chk("dis_abc_vs_de", {27'b0, dis1}, 32'b11000);
    chk("disq_held_in_reset", {27'b0, disq1}, 32'd0);

    // Registered path and asynchronous reset.
    @(negedge clk);
    set1(5'b11111);
    rst = 1'b0;
    tick;
    chk("xq_after_edge", {31'b0, xq1}, 32'd1);
    chk("disq_unanimous", {27'b0, disq1}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("xq_async_rst", {31'b0, xq1}, 32'd0);
    chk("x_during_rst", {31'b0, x1}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Sticky dissent flags.
    set1(5'b01111);
    tick;
    chk("disq_e", {27'b0, disq1}, 32'b10000);
    set1(5'b11111);
    tick;
    chk("disq_e_held", {27'b0, disq1}, 32'b10000);
    set1(5'b11110);
    tick;
    chk("disq_accum", {27'b0, disq1}, 32'b10001);
    set1(5'b11111);
    clr = 1'b1;
    tick;
    chk("disq_clr", {27'b0, disq1}, 32'd0);
    set1(5'b10111);
    tick;
    chk("disq_clr_set_wins", {27'b0, disq1}, 32'b01000);
    clr = 1'b0;
    set1(5'b11111);
    tick;
    chk("disq_d_held", {27'b0, disq1}, 32'b01000);
    #2 rst = 1'b1;
    #1;
    chk("disq_async_rst", {27'b0, disq1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Multi-lane vote.
    a4 = 4'hF; b4 = 4'hF; c4 = 4'h0; d4 = 4'h3; e4 = 4'hC;
    #1;
    chk("w4_x", {28'b0, x4}, 32'hF);
    chk("w4_un", {31'b0, un4}, 32'd0);
    chk("w4_dis", {27'b0, dis4}, 32'b11100);
    tick;
    chk("w4_xq", {28'b0, xq4}, 32'hF);
    chk("w4_disq", {27'b0, disq4}, 32'b11100);
    a4 = 4'hA; b4 = 4'hA; c4 = 4'hA; d4 = 4'hA; e4 = 4'hA;
    #1;
    chk("w4_un_mixed_lanes", {31'b0, un4}, 32'd1);
    chk("w4_x_mixed", {28'b0, x4}, 32'hA);
    e4 = 4'hB;
    #1;
    chk("w4_un_one_lane", {31'b0, un4}, 32'd0);
    chk("w4_dis_e_lane0", {27'b0, dis4}, 32'b10000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
